// File: rtl/matriz_loader.sv
// ---------------------------------------------------------------------------
// matriz_loader
//
// Front end for the determinant units. Elements arrive one byte per
// valid/ready handshake in row-major order and are packed into a
// DIM_MAX x DIM_MAX bus. Element (i,j) occupies bits
// [(i*DIM_MAX + j)*ELEM_W +: ELEM_W]. Only the top-left NxN block is ever
// written; every other position stays zero, so the downstream blocks can
// always work on the full bus.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous, active-high reset
//   start        : one-cycle pulse that begins a load of dimension 'size'
//   size         : matrix dimension N, legal 2..DIM_MAX, sampled with start
//   in_valid     : in_data carries an element
//   in_data      : element byte (raw bits)
//   in_ready     : an element is accepted this cycle if in_valid is high
//   matriz_A     : packed matrix, row-major
//   matrix_valid : matriz_A holds a complete NxN matrix
//   busy         : a load is in progress
//   done         : one-cycle pulse the cycle after the last element lands
//   size_err     : one-cycle pulse after a start with an illegal size
// ---------------------------------------------------------------------------
module matriz_loader #(
    parameter int ELEM_W  = 8,
    parameter int DIM_MAX = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [2:0]                          size,
    input  logic                                in_valid,
    input  logic [ELEM_W-1:0]                   in_data,
    output logic                                in_ready,
    output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0]   matriz_A,
    output logic                                matrix_valid,
    output logic                                busy,
    output logic                                done,
    output logic                                size_err
);

    localparam int BUS_W = DIM_MAX * DIM_MAX * ELEM_W;
    localparam int IDX_W = $clog2(DIM_MAX * DIM_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         n_q, n_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         col_q, col_d;
    logic [BUS_W-1:0]   mat_q, mat_d;
    logic               done_q, done_d;
    logic               size_err_q, size_err_d;

    logic               start_ok;
    logic               accept;
    logic               last_elem;
    logic [IDX_W-1:0]   wr_idx;

    // Dimensions 0, 1 and anything above DIM_MAX are rejected.
    function automatic logic size_legal(input logic [2:0] s);
        return (s >= 3'd2) && (32'(s) <= DIM_MAX);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            mat_q      <= '0;
            done_q     <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            row_q      <= row_d;
            col_q      <= col_d;
            mat_q      <= mat_d;
            done_q     <= done_d;
            size_err_q <= size_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        row_d      = row_q;
        col_d      = col_q;
        mat_d      = mat_q;
        done_d     = 1'b0;
        size_err_d = 1'b0;

        start_ok   = start && size_legal(size);
        accept     = (state_q == S_LOAD) && in_valid;
        last_elem  = (row_q == n_q - 3'd1) && (col_q == n_q - 3'd1);
        wr_idx     = IDX_W'(row_q) * IDX_W'(DIM_MAX) + IDX_W'(col_q);

        if (start_ok) begin
            // A legal start always wins over a same-edge handshake: the
            // byte on in_data is dropped along with any partial matrix.
            mat_d   = '0;
            n_d     = size;
            row_d   = '0;
            col_d   = '0;
            state_d = S_LOAD;
        end else begin
            // An illegal start only flags; any load in progress carries on.
            if (start) begin
                size_err_d = 1'b1;
            end
            if (accept) begin
                mat_d[32'(wr_idx) * ELEM_W +: ELEM_W] = in_data;
                if (last_elem) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_FULL;
                    done_d  = 1'b1;
                end else if (col_q == n_q - 3'd1) begin
                    col_d = '0;
                    row_d = row_q + 3'd1;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
        end
    end

    assign in_ready     = (state_q == S_LOAD);
    assign busy         = (state_q == S_LOAD);
    assign matrix_valid = (state_q == S_FULL);
    assign matriz_A     = mat_q;
    assign done         = done_q;
    assign size_err     = size_err_q;

endmodule

// File: tb/tb_matriz_loader.sv
module tb_matriz_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   size;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [199:0] matriz_A;
    logic         matrix_valid;
    logic         busy;
    logic         done;
    logic         size_err;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;

    // Reference model: matrix as a flat list of 25 bytes, a count of
    // accepted elements and the loaded dimension.
    bit       m_load, m_full, m_done, m_err;
    int       m_n, m_k;
    byte      m_mat[25];

    matriz_loader dut (
        .clk(clk), .rst(rst), .start(start), .size(size),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .matriz_A(matriz_A), .matrix_valid(matrix_valid), .busy(busy),
        .done(done), .size_err(size_err)
    );

    always #5 clk = ~clk;

    function automatic logic [199:0] pack_model();
        logic [199:0] v;
        v = '0;
        for (int i = 0; i < 25; i++) v[i*8 +: 8] = m_mat[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge: advance the model from the inputs now on the
    // pins, then compare every output just after the edge.
    task automatic tick();
        if (rst) begin
            m_load = 0; m_full = 0; m_done = 0; m_err = 0; m_n = 0; m_k = 0;
            for (int i = 0; i < 25; i++) m_mat[i] = 0;
        end else begin
            m_done = 0; m_err = 0;
            if (start && size >= 2 && size <= 5) begin
                for (int i = 0; i < 25; i++) m_mat[i] = 0;
                m_n = int'(size); m_k = 0; m_load = 1; m_full = 0;
            end else begin
                if (start) m_err = 1;
                if (m_load && in_valid) begin
                    m_mat[(m_k / m_n) * 5 + (m_k % m_n)] = in_data;
                    m_k++;
                    hs_cnt++;
                    if (m_k == m_n * m_n) begin
                        m_load = 0; m_full = 1; m_done = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        chk("in_ready",     200'(in_ready),     200'(m_load));
        chk("busy",         200'(busy),         200'(m_load));
        chk("matrix_valid", 200'(matrix_valid), 200'(m_full));
        chk("done",         200'(done),         200'(m_done));
        chk("size_err",     200'(size_err),     200'(m_err));
        chk("matriz_A",     matriz_A,           pack_model());
    endtask

    task automatic do_start(input logic [2:0] s);
        start = 1; size = s;
        tick();
        start = 0;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1; in_data = d;
        tick();
        in_valid = 0;
    endtask

    initial begin
        rst = 1; start = 0; size = 0; in_valid = 0; in_data = 0;
        tick();
        tick();
        rst = 0;
        tick();

        // Illegal sizes while idle
        do_start(3'd6);
        do_start(3'd0);
        tick();

        // 2x2 back-to-back
        done_cnt = 0; hs_cnt = 0;
        do_start(3'd2);
        send(8'd3); send(8'd5); send(8'd2); send(8'd4);
        tick();
        chk("t1_bus", matriz_A, 200'h04020000000503);
        chk("t1_done_cnt", 200'(done_cnt), 200'd1);
        chk("t1_hs_cnt", 200'(hs_cnt), 200'd4);

        // 5x5 with in_valid toggling
        done_cnt = 0;
        do_start(3'd5);
        for (int c = 0; c < 80 && !(done === 1'b1); c++) begin
            in_valid = c[0] ? 1'b0 : 1'b1;
            in_data  = 8'(m_k + 1);
            tick();
        end
        in_valid = 0;
        chk("t2_done_seen", 200'(done_cnt), 200'd1);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                chk("t2_elem", 200'(matriz_A[i*40 + j*8 +: 8]), 200'(5*i + j + 1));

        // Restart over a partial 3x3 with a coincident byte
        do_start(3'd3);
        for (int i = 0; i < 4; i++) send(8'($urandom));
        start = 1; size = 3'd2; in_valid = 1; in_data = 8'hAA;
        tick();
        start = 0; in_valid = 0;
        chk("t4_cleared", matriz_A, 200'd0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) send(8'($urandom));
        tick();
        chk("t4_done_cnt", 200'(done_cnt), 200'd1);

        // Reset mid 4x4 load
        do_start(3'd4);
        for (int i = 0; i < 7; i++) send(8'($urandom));
        rst = 1;
        tick();
        rst = 0;
        chk("t5_bus_zero", matriz_A, 200'd0);
        for (int i = 0; i < 3; i++) send(8'($urandom));

        // Hold in_valid on a full 3x3 matrix
        do_start(3'd3);
        for (int i = 0; i < 9; i++) send(8'($urandom));
        done_cnt = 0;
        in_valid = 1; in_data = 8'hFF;
        for (int i = 0; i < 10; i++) tick();
        in_valid = 0;
        chk("t6_no_done", 200'(done_cnt), 200'd0);

        // Random traffic: random sizes, valids, restarts and illegal starts
        for (int c = 0; c < 800; c++) begin
            start    = ($urandom_range(0, 29) == 0);
            size     = 3'($urandom_range(0, 7));
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0; start = 0; in_valid = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
